// File: rtl/cache_mem_arbiter.sv
// rtl/cache_mem_arbiter.sv - I/D cache fill and store arbiter for a 4-cycle pipelined memory
// Fills are 8 halfword-addressed words; stores are single write-through cycles.

module cache_mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  input  logic        d_req,
  input  logic [15:0] d_addr,
  input  logic        d_wr_req,
  input  logic [15:0] d_wr_data,
  input  logic [15:0] mem_data_in,
  input  logic        mem_valid_in,
  output logic        mem_enable,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_out,
  output logic        i_grant,
  output logic        d_grant,
  output logic        i_data_valid,
  output logic        d_data_valid,
  output logic [15:0] fill_data,
  output logic [2:0]  fill_word,
  output logic        i_fill_done,
  output logic        d_fill_done,
  output logic        wr_done
);

  typedef enum logic [1:0] {IDLE, FILL_I, FILL_D, WRITE} state_t;

  state_t      state, state_nxt;
  logic [15:0] base;
  logic [3:0]  issue_cnt;
  logic [3:0]  ret_cnt;
  logic        last_fill_d;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;

  logic filling, issuing, ret_valid, fill_last;

  assign filling   = (state == FILL_I) || (state == FILL_D);
  assign issuing   = filling && !issue_cnt[3];
  assign ret_valid = filling && mem_valid_in;
  assign fill_last = ret_valid && (ret_cnt == 4'd7);

  always_comb begin
    state_nxt    = state;
    mem_enable   = 1'b0;
    mem_wr       = 1'b0;
    mem_addr     = 16'h0000;
    mem_data_out = 16'h0000;
    i_data_valid = 1'b0;
    d_data_valid = 1'b0;
    fill_data    = 16'h0000;
    fill_word    = 3'd0;
    i_fill_done  = 1'b0;
    d_fill_done  = 1'b0;
    wr_done      = 1'b0;

    case (state)
      IDLE: begin
        // Stores win outright; a fill tie goes to the side that was not served last.
        if (d_wr_req)
          state_nxt = WRITE;
        else if (i_req && d_req)
          state_nxt = last_fill_d ? FILL_I : FILL_D;
        else if (i_req)
          state_nxt = FILL_I;
        else if (d_req)
          state_nxt = FILL_D;
      end
      FILL_I, FILL_D: begin
        if (issuing) begin
          mem_enable = 1'b1;
          mem_addr   = base + {12'd0, issue_cnt[2:0], 1'b0};
        end
        if (ret_valid) begin
          i_data_valid = (state == FILL_I);
          d_data_valid = (state == FILL_D);
          fill_data    = mem_data_in;
          fill_word    = ret_cnt[2:0];
        end
        if (fill_last) begin
          i_fill_done = (state == FILL_I);
          d_fill_done = (state == FILL_D);
          state_nxt   = IDLE;
        end
      end
      WRITE: begin
        mem_enable   = 1'b1;
        mem_wr       = 1'b1;
        mem_addr     = wr_addr;
        mem_data_out = wr_data;
        wr_done      = 1'b1;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign i_grant = (state == FILL_I);
  assign d_grant = (state == FILL_D);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      base        <= 16'h0000;
      issue_cnt   <= 4'd0;
      ret_cnt     <= 4'd0;
      last_fill_d <= 1'b1;
      wr_addr     <= 16'h0000;
      wr_data     <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        issue_cnt <= 4'd0;
        ret_cnt   <= 4'd0;
        if (state_nxt == FILL_I)
          base <= i_addr & 16'hFFF0;
        else if (state_nxt == FILL_D)
          base <= d_addr & 16'hFFF0;
        if (state_nxt == WRITE) begin
          wr_addr <= d_addr;
          wr_data <= d_wr_data;
        end
      end else begin
        if (issuing)
          issue_cnt <= issue_cnt + 4'd1;
        if (ret_valid)
          ret_cnt <= ret_cnt + 4'd1;
        if (fill_last)
          last_fill_d <= (state == FILL_D);
      end
    end
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb/tb_cache_mem_arbiter.sv - directed self-checking bench for cache_mem_arbiter
module tb_cache_mem_arbiter;

    logic        clk, rst;
    logic        i_req, d_req, d_wr_req;
    logic [15:0] i_addr, d_addr, d_wr_data;
    logic [15:0] mem_data_in;
    logic        mem_valid_in;
    logic        mem_enable, mem_wr;
    logic [15:0] mem_addr, mem_data_out;
    logic        i_grant, d_grant, i_data_valid, d_data_valid;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        i_fill_done, d_fill_done, wr_done;

    int n_checks = 0;
    int n_fail   = 0;
    int seen     = 0;

    logic [16:0] pipe [4] = '{default: '0};

    cache_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr),
        .d_req(d_req), .d_addr(d_addr),
        .d_wr_req(d_wr_req), .d_wr_data(d_wr_data),
        .mem_data_in(mem_data_in), .mem_valid_in(mem_valid_in),
        .mem_enable(mem_enable), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_data_out(mem_data_out),
        .i_grant(i_grant), .d_grant(d_grant),
        .i_data_valid(i_data_valid), .d_data_valid(d_data_valid),
        .fill_data(fill_data), .fill_word(fill_word),
        .i_fill_done(i_fill_done), .d_fill_done(d_fill_done),
        .wr_done(wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        pipe[0] <= {mem_enable & ~mem_wr, mem_addr ^ 16'hA5A5};
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_valid_in = pipe[3][16];
    assign mem_data_in  = pipe[3][15:0];

    task automatic bad(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_fail++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_fill(input bit side_d, input logic [15:0] base, input int drop_at);
        logic [1:0]  exp_side;
        logic [15:0] exp_addr;
        logic [15:0] exp_data;
        logic [1:0]  exp_done;
        exp_side = side_d ? 2'b01 : 2'b10;
        for (int c = 1; c <= 12; c++) begin
            step();
            n_checks++;
            if ({i_grant, d_grant} !== exp_side) bad("grant", {i_grant, d_grant}, exp_side);
            n_checks++;
            if (mem_enable !== (c <= 8)) bad("mem_enable", mem_enable, (c <= 8));
            n_checks++;
            if (mem_wr !== 1'b0) bad("mem_wr", mem_wr, 1'b0);
            exp_addr = (c <= 8) ? base + 16'(2*(c-1)) : 16'h0000;
            n_checks++;
            if (mem_addr !== exp_addr) bad("mem_addr", mem_addr, exp_addr);
            if (c >= 5) begin
                n_checks++;
                if ({i_data_valid, d_data_valid} !== exp_side) bad("data_valid", {i_data_valid, d_data_valid}, exp_side);
                n_checks++;
                if (fill_word !== 3'(c-5)) bad("fill_word", fill_word, 3'(c-5));
                exp_data = (base + 16'(2*(c-5))) ^ 16'hA5A5;
                n_checks++;
                if (fill_data !== exp_data) bad("fill_data", fill_data, exp_data);
            end else begin
                n_checks++;
                if ({i_data_valid, d_data_valid} !== 2'b00) bad("data_valid_early", {i_data_valid, d_data_valid}, 2'b00);
            end
            exp_done = (c == 12) ? exp_side : 2'b00;
            n_checks++;
            if ({i_fill_done, d_fill_done} !== exp_done) bad("fill_done", {i_fill_done, d_fill_done}, exp_done);
            if (c == drop_at) begin
                i_req = 1'b0;
                d_req = 1'b0;
            end
        end
    endtask

    task automatic idle_check();
        step();
        n_checks++;
        if ({i_grant, d_grant, mem_enable, wr_done} !== 4'b0000) bad("idle_grant", {i_grant, d_grant, mem_enable, wr_done}, 4'b0000);
    endtask

    initial begin
        rst = 1'b1; i_req = 1'b0; d_req = 1'b0; d_wr_req = 1'b0;
        i_addr = '0; d_addr = '0; d_wr_data = '0;
        #2;
        n_checks++;
        if ({mem_enable, mem_wr, mem_addr, mem_data_out, i_grant, d_grant, i_data_valid, d_data_valid, fill_data, fill_word, i_fill_done, d_fill_done, wr_done} !== 60'h0)
            bad("reset_outputs", {mem_enable, mem_wr, mem_addr, mem_data_out, i_grant, d_grant, i_data_valid, d_data_valid, fill_data, fill_word, i_fill_done, d_fill_done, wr_done}, 64'h0);
        step();
        step();
        rst = 1'b0;
        idle_check();

        i_req = 1'b1; i_addr = 16'h1236;
        run_fill(1'b0, 16'h1230, 12);
        idle_check();

        rst = 1'b1;
        step();
        rst = 1'b0;
        i_req = 1'b1; d_req = 1'b1; i_addr = 16'h0A10; d_addr = 16'h7F35;
        run_fill(1'b0, 16'h0A10, 0);
        i_req = 1'b0;
        idle_check();
        run_fill(1'b1, 16'h7F30, 0);
        i_req = 1'b1;
        idle_check();
        run_fill(1'b0, 16'h0A10, 12);
        idle_check();

        d_wr_req = 1'b1; d_addr = 16'h4000; d_wr_data = 16'hBEEF; i_req = 1'b1; i_addr = 16'h5678;
        step();
        n_checks++;
        if ({mem_enable, mem_wr, wr_done, i_grant, d_grant} !== 5'b11100) bad("wr_bus", {mem_enable, mem_wr, wr_done, i_grant, d_grant}, 5'b11100);
        n_checks++;
        if (mem_addr !== 16'h4000) bad("wr_addr", mem_addr, 16'h4000);
        n_checks++;
        if (mem_data_out !== 16'hBEEF) bad("wr_data", mem_data_out, 16'hBEEF);
        d_wr_req = 1'b0;
        step();
        n_checks++;
        if ({mem_wr, wr_done, mem_data_out} !== 18'h0) bad("post_wr", {mem_wr, wr_done, mem_data_out}, 18'h0);
        run_fill(1'b0, 16'h5670, 12);
        idle_check();

        i_req = 1'b1; i_addr = 16'hFFF9;
        run_fill(1'b0, 16'hFFF0, 2);
        idle_check();
        idle_check();

        i_req = 1'b1; i_addr = 16'h2004;
        for (int c = 1; c <= 7; c++) step();
        n_checks++;
        if ({i_data_valid, fill_word} !== 4'b1010) bad("pre_abort_word", {i_data_valid, fill_word}, 4'b1010);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({mem_enable, mem_wr, mem_addr, mem_data_out, i_grant, d_grant, i_data_valid, d_data_valid, fill_data, fill_word, i_fill_done, d_fill_done, wr_done} !== 60'h0)
            bad("abort_outputs", {mem_enable, mem_wr, mem_addr, mem_data_out, i_grant, d_grant, i_data_valid, d_data_valid, fill_data, fill_word, i_fill_done, d_fill_done, wr_done}, 64'h0);
        i_req = 1'b0;
        step();
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (mem_valid_in) seen++;
            n_checks++;
            if ({i_data_valid, i_fill_done, i_grant, mem_enable} !== 4'b0000) bad("late_ignored", {i_data_valid, i_fill_done, i_grant, mem_enable}, 4'b0000);
        end
        n_checks++;
        if ((seen > 0) !== 1'b1) bad("late_valid_seen", (seen > 0), 1'b1);
        i_req = 1'b1; i_addr = 16'h2004;
        run_fill(1'b0, 16'h2000, 12);
        idle_check();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cache_mem_arbiter.md
CACHE_MEM_ARBITER -- requirements
Module: cache_mem_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state on rising edge.
REQ-002 SHALL have: rst  input  1  asynchronous, active-high reset.
REQ-003 SHALL have: i_req  input  1  I-cache fill request (level, held while I-side miss pending).
REQ-004 SHALL have: i_addr  input  16  I-side miss address.
REQ-005 SHALL have: d_req  input  1  D-cache fill request (level).
REQ-006 SHALL have: d_addr  input  16  D-side miss/store address.
REQ-007 SHALL have: d_wr_req  input  1  D-side write-through store request.
REQ-008 SHALL have: d_wr_data  input  16  store data.
REQ-009 SHALL have: mem_data_in  input  16 and mem_valid_in  input  1  read data and valid from 4-cycle pipelined memory.
REQ-010 SHALL have: mem_enable, mem_wr  output  1 each; mem_addr, mem_data_out  output  16 each; memory request bus.
REQ-011 SHALL have: i_grant, d_grant  output  1 each  side currently owning a fill.
REQ-012 SHALL have: i_data_valid, d_data_valid  output  1 each; fill_data  output  16; fill_word  output  3  word index of fill_data.
REQ-013 SHALL have: i_fill_done, d_fill_done, wr_done  output  1 each  single-cycle completion pulses.

Function
REQ-014 SHALL implement registered states IDLE, FILL_I, FILL_D, WRITE; grants decoded from state (i_grant=FILL_I, d_grant=FILL_D).
REQ-015 In IDLE, priority at a clock edge: d_wr_req -> WRITE; else both fill requests -> side not served by last fill (last_fill register); else the single requester; else stay IDLE.
REQ-016 On entering FILL_x, SHALL capture base = {x_addr[15:4], 4'h0}; issue counter and return counter (both 4-bit) cleared.
REQ-017 In FILL_x, mem_enable=1, mem_wr=0, mem_addr = base + 2*issue_count while issue_count < 8; issue_count increments each cycle; mem_enable=0 once 8 issued.
REQ-018 In FILL_x, each mem_valid_in=1 SHALL drive x_data_valid=1 combinationally, fill_data=mem_data_in, fill_word=return_count[2:0], then increment return_count.
REQ-019 On the 8th mem_valid_in of a fill, x_fill_done=1 that cycle, last_fill<=x, state<=IDLE; at least one IDLE cycle between transactions.
REQ-020 Request deassertion during FILL_x SHALL be ignored; fill runs to 8 words.
REQ-021 On accepting a store, SHALL capture d_addr and d_wr_data; WRITE lasts exactly one cycle: mem_enable=1, mem_wr=1, mem_addr/mem_data_out = captured values, wr_done=1; next state IDLE.
REQ-022 mem_valid_in outside FILL_x SHALL be ignored (no data_valid, counters unchanged).
REQ-023 Outside WRITE, mem_wr=0 and mem_data_out=16'h0000; outside active issue, mem_addr=16'h0000.
REQ-024 Only one of i_grant/d_grant/WRITE active at any cycle; the non-granted side's data_valid/fill_done SHALL stay 0.
REQ-025 Latency: request seen at edge N -> first mem_enable cycle N+1; with 4-cycle memory, fill_done at cycle N+12.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, counters=0, base/captured regs=0, last_fill=D (so first tie goes to I); all outputs 0.
REQ-027 rst asserted mid-fill or mid-write SHALL abort without fill_done/wr_done pulses; returned data after rst release while IDLE ignored.

Verification
REQ-028 i_req=1, i_addr=16'h1236 -> mem_addr 16'h1230,1232,...,123E on 8 consecutive cycles; 8 i_data_valid with fill_word 0..7; i_fill_done on 8th; d_* stay 0.
REQ-029 i_req and d_req both rise from reset -> FILL_I first; d_req still held -> FILL_D after one IDLE cycle; next tie grants I.
REQ-030 d_wr_req=1, d_addr=16'h4000, d_wr_data=16'hBEEF with i_req=1 -> one WRITE cycle (mem_wr=1, addr 16'h4000, data 16'hBEEF, wr_done=1), then FILL_I.
REQ-031 i_req dropped after 2 cycles of FILL_I -> all 8 addresses still issued, i_fill_done still pulses.
REQ-032 rst pulsed after 3rd returned word -> outputs 0 immediately, late mem_valid_in ignored, no i_fill_done; new i_req restarts at word 0.
